// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and read-owner encoding for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_CPU  = 2'd1;
  localparam owner_t OWN_EXT  = 2'd2;

  // True when a byte address reaches beyond the SRAM word range.
  function automatic logic addr_oob(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - 4-bit saturating host starvation counter with limit flag
module dmem_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (inc && cnt != 4'hF) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (int'(cnt) >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data SRAM arbiter between the MEM stage and the host port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              oob_err
);

  logic              at_limit;
  logic              host_wins;
  logic              cpu_gnt;
  logic              any_gnt;
  logic              gnt_wen;
  logic [31:0]       gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  owner_t            owner;
  owner_t            owner_next;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;

  // Host wins when the pipeline is frozen, when it has waited too long, or when the CPU is idle.
  assign host_wins = ~cpu_enable | at_limit | ~cpu_req;
  assign ext_gnt   = ext_req & host_wins;
  assign cpu_gnt   = cpu_req & ~host_wins;
  assign cpu_stall = cpu_req & cpu_enable & ~cpu_gnt;
  assign any_gnt   = cpu_gnt | ext_gnt;

  dmem_starve_ctr #(
    .LIMIT (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (ext_req & ~ext_gnt),
    .clr      (ext_gnt | ~ext_req),
    .at_limit (at_limit)
  );

  always_comb begin
    gnt_wen   = 1'b0;
    gnt_addr  = 32'd0;
    gnt_wdata = '0;
    if (cpu_gnt) begin
      gnt_wen   = cpu_wen;
      gnt_addr  = cpu_addr;
      gnt_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      gnt_wen   = ext_wen;
      gnt_addr  = ext_addr;
      gnt_wdata = ext_wdata;
    end
  end

  assign mem_addr  = gnt_addr[ADDR_W+1:2];
  assign mem_wen   = any_gnt & gnt_wen;
  assign mem_ren   = any_gnt & ~gnt_wen;
  assign mem_wdata = gnt_wdata;

  always_comb begin
    owner_next = OWN_NONE;
    if (cpu_gnt && !cpu_wen) begin
      owner_next = OWN_CPU;
    end else if (ext_gnt && !ext_wen) begin
      owner_next = OWN_EXT;
    end
  end

  // The owner register tags the SRAM output for the one cycle it is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      oob_err     <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      owner <= owner_next;
      if (any_gnt && addr_oob(gnt_addr, ADDR_W)) begin
        oob_err <= 1'b1;
      end
      if (owner == OWN_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (owner == OWN_EXT) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign ext_rvalid = (owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_q;

endmodule
